// File: rtl/cmd_response_tx_pkg.sv
// cmd_resp_pkg: response framing constants, FSM states and the packet byte selector.
`timescale 1ns/1ps
package cmd_resp_pkg;
  localparam logic [7:0] RESP_HEADER = 8'h55;
  localparam int RESP_LEN = 7;
  localparam int IDX_W = $clog2(RESP_LEN);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  function automatic logic [7:0] resp_byte(input logic [7:0] op, input logic [31:0] cmd, input logic [IDX_W-1:0] idx);
    logic [7:0] sum;
    sum = op ^ cmd[31:24] ^ cmd[23:16] ^ cmd[15:8] ^ cmd[7:0];
    case (idx)
      3'd0: resp_byte = RESP_HEADER;
      3'd1: resp_byte = op;
      3'd2: resp_byte = cmd[31:24];
      3'd3: resp_byte = cmd[23:16];
      3'd4: resp_byte = cmd[15:8];
      3'd5: resp_byte = cmd[7:0];
      default: resp_byte = sum;
    endcase
  endfunction
endpackage

// File: rtl/cmd_response_tx_if.sv
// cmd_response_tx_if: decoder command inputs and UART transmit strobe/byte outputs.
`timescale 1ns/1ps
interface cmd_response_tx_if;
  logic        cmd_valid;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        trans_en;
  logic [7:0]  data_out;
  modport master (output cmd_valid, opcode, command, input trans_en, data_out);
  modport slave (input cmd_valid, opcode, command, output trans_en, data_out);
endinterface

// File: rtl/cmd_response_tx_byte_pacer.sv
// byte_pacer: after start, pulses done on the last of BYTE_PERIOD-1 gap cycles.
`timescale 1ns/1ps
module byte_pacer #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FRAME_BITS = 11
) (
  input  logic start,
  input  logic clock,
  input  logic reset,
  output logic done
);
  localparam int BYTE_PERIOD = FRAME_BITS * CLKS_PER_BIT;
  localparam int CNT_W = $clog2(BYTE_PERIOD);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  always_comb begin
    run_d = start | (run_q & (cnt_q != '0));
    cnt_d = start ? CNT_W'(BYTE_PERIOD - 2) : (run_q & (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
  assign done = run_q & (cnt_q == '0);
endmodule

// File: rtl/cmd_response_tx.sv
// cmd_response_tx: frames each decoded command into a paced 7-byte UART response.
`timescale 1ns/1ps
module cmd_response_tx
  import cmd_resp_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FRAME_BITS = 11
) (
  input  logic       clock,
  input  logic       reset,
  cmd_response_tx_if.slave bus,
  output logic       busy,
  output logic [7:0] drop_count
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] op_q, op_d, pop_q, pop_d, drop_q, drop_d, dout_q, dout_d;
  logic [31:0] cmd_q, cmd_d, pcmd_q, pcmd_d;
  logic cv_q, pv_q, pv_d, te_q, te_d, start, done;
  logic rise, last, gap_end, drain, to_idle;
  byte_pacer #(.CLKS_PER_BIT(CLKS_PER_BIT), .FRAME_BITS(FRAME_BITS)) u_pacer (
    .start(start), .clock(clock), .reset(reset), .done(done)
  );
  assign rise    = bus.cmd_valid & ~cv_q;
  assign last    = idx_q == IDX_W'(RESP_LEN - 1);
  assign gap_end = (state_q == GAP) & done;
  assign drain   = gap_end & last & pv_q;
  // A packet ending with nothing pending behaves like IDLE for a same-cycle rise.
  assign to_idle = (state_q == IDLE) | (gap_end & last & ~pv_q);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    op_d = op_q;
    cmd_d = cmd_q;
    pv_d = pv_q;
    pop_d = pop_q;
    pcmd_d = pcmd_q;
    drop_d = drop_q;
    start = 1'b0;
    te_d = 1'b0;
    dout_d = dout_q;
    if (state_q == SEND) begin
      te_d = 1'b1;
      dout_d = resp_byte(op_q, cmd_q, idx_q);
      start = 1'b1;
      state_d = GAP;
    end
    if (gap_end) begin
      state_d = (!last || pv_q) ? SEND : IDLE;
      idx_d = last ? '0 : idx_q + 1'b1;
    end
    if (drain) begin
      op_d = pop_q;
      cmd_d = pcmd_q;
      pv_d = 1'b0;
    end
    if (rise && to_idle) begin
      op_d = bus.opcode;
      cmd_d = bus.command;
      idx_d = '0;
      state_d = SEND;
    end else if (rise && (!pv_q || drain)) begin
      pop_d = bus.opcode;
      pcmd_d = bus.command;
      pv_d = 1'b1;
    end else if (rise) begin
      drop_d = drop_q + 8'(drop_q != 8'hff);
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      op_q <= '0;
      cmd_q <= '0;
      pv_q <= 1'b0;
      pop_q <= '0;
      pcmd_q <= '0;
      drop_q <= '0;
      te_q <= 1'b0;
      dout_q <= '0;
      cv_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      op_q <= op_d;
      cmd_q <= cmd_d;
      pv_q <= pv_d;
      pop_q <= pop_d;
      pcmd_q <= pcmd_d;
      drop_q <= drop_d;
      te_q <= te_d;
      dout_q <= dout_d;
      cv_q <= bus.cmd_valid;
    end
  end
  assign bus.trans_en = te_q;
  assign bus.data_out = dout_q;
  assign busy = (state_q != IDLE) | pv_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_cmd_response_tx.sv
// tb_cmd_response_tx: table vectors, directed corner sequences and random stimulus against a launch-time model.
`timescale 1ns/1ps
module tb_cmd_response_tx;
  localparam int CPB = 4, FB = 10, BP = CPB * FB;
  logic clk = 1'b0, rst = 1'b1;
  logic busy;
  logic [7:0] drop_count;
  always #5 clk = ~clk;
  cmd_response_tx_if bus();
  cmd_response_tx #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB)) dut (
    .clock(clk), .reset(rst), .bus(bus.slave), .busy(busy), .drop_count(drop_count)
  );
  typedef struct {int e; logic [7:0] b;} strobe_t;
  typedef struct {logic [7:0] op; logic [31:0] cmd; logic [7:0] sum;} vec_t;
  strobe_t exp_q[$];
  logic [7:0] log_b[$];
  int log_e[$];
  int edges = 0, n_cmp = 0, n_bad = 0;
  logic s_cv;
  logic [7:0] s_op, m_pop;
  logic [31:0] s_cmd, m_pcmd;
  logic m_prev = 1'b1, m_active = 1'b0, m_pend = 1'b0;
  int m_end = 0, m_drop = 0;

  function automatic logic [7:0] pkt_byte(input logic [7:0] op, input logic [31:0] cmd, input int i);
    logic [7:0] b[7];
    b[0] = 8'h55;
    b[1] = op;
    for (int j = 0; j < 4; j++) b[2+j] = cmd[31-8*j -: 8];
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    return b[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, want, edges);
    end
  endtask

  // A packet launched at edge l strobes at l+1+i*BP and frees the FSM at l+7*BP.
  task automatic launch(input int l, input logic [7:0] op, input logic [31:0] cmd);
    strobe_t s;
    m_active = 1'b1;
    m_end = l + 7 * BP;
    for (int i = 0; i < 7; i++) begin
      s.e = l + 1 + i * BP;
      s.b = pkt_byte(op, cmd, i);
      exp_q.push_back(s);
    end
  endtask

  always @(posedge clk) begin
    edges <= edges + 1;
    s_cv <= bus.cmd_valid;
    s_op <= bus.opcode;
    s_cmd <= bus.command;
  end

  always @(negedge clk) begin : model
    logic rise;
    strobe_t s;
    if (rst) begin
      m_active = 1'b0;
      m_pend = 1'b0;
      m_prev = 1'b1;
      m_drop = 0;
      exp_q.delete();
    end else begin
      if (bus.trans_en) begin
        log_b.push_back(bus.data_out);
        log_e.push_back(edges);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got byte %0h at edge %0d, want no strobe", bus.data_out, edges);
        end else begin
          s = exp_q.pop_front();
          chk("strobe_edge", edges, s.e);
          chk("strobe_byte", bus.data_out, s.b);
        end
      end
      rise = s_cv & ~m_prev;
      m_prev = s_cv;
      if (m_active && edges == m_end) begin
        if (m_pend) begin
          launch(edges, m_pop, m_pcmd);
          m_pend = 1'b0;
        end else m_active = 1'b0;
      end
      if (rise) begin
        if (!m_active) launch(edges, s_op, s_cmd);
        else if (!m_pend) begin
          m_pend = 1'b1;
          m_pop = s_op;
          m_pcmd = s_cmd;
        end else if (m_drop < 255) m_drop++;
      end
      chk("busy", busy, m_active | m_pend);
      chk("drop_count", drop_count, m_drop);
    end
  end

  task automatic rise_cmd(input logic [7:0] op, input logic [31:0] cmd, output int k);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.opcode = op;
    bus.command = cmd;
    @(negedge clk);
    k = edges;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy; i++) begin
      @(negedge clk);
      #1;
    end
    chk("idle_within_bound", busy, 0);
  endtask

  initial begin
    vec_t vt[5];
    int k, n0, n1;
    vt[0] = '{8'h01, 32'h12345678, 8'h09};
    vt[1] = '{8'h00, 32'h00000000, 8'h00};
    vt[2] = '{8'hFF, 32'hFFFFFFFF, 8'hFF};
    vt[3] = '{8'hA5, 32'h0000005A, 8'hFF};
    vt[4] = '{8'h80, 32'h01020408, 8'h8F};
    bus.cmd_valid = 1'b1;
    bus.opcode = '0;
    bus.command = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_trans_en", bus.trans_en, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("held_through_reset_busy", busy, 0);
    chk("held_through_reset_strobes", log_b.size(), 0);
    @(negedge clk) bus.cmd_valid = 1'b0;
    for (int v = 0; v < 5; v++) begin
      n0 = log_b.size();
      rise_cmd(vt[v].op, vt[v].cmd, k);
      wait_idle(400);
      chk("vec_count", log_b.size(), n0 + 7);
      chk("vec_header", log_b[n0], 8'h55);
      chk("vec_opcode", log_b[n0+1], vt[v].op);
      chk("vec_checksum", log_b[n0+6], vt[v].sum);
      chk("vec_first_latency", log_e[n0], k + 1);
      chk("vec_hold_data_out", bus.data_out, vt[v].sum);
    end
    n0 = log_b.size();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.opcode = 8'h3C;
    bus.command = 32'hCAFEF00D;
    repeat (100) @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_idle(400);
    chk("held_high_one_packet", log_b.size(), n0 + 7);
    rise_cmd(8'h3D, 32'h0BADBEEF, k);
    wait_idle(400);
    chk("held_high_second_packet", log_b.size(), n0 + 14);
    n0 = log_b.size();
    rise_cmd(8'hA1, 32'h11111111, k);
    repeat (20) @(negedge clk);
    rise_cmd(8'hA2, 32'h22222222, k);
    repeat (20) @(negedge clk);
    rise_cmd(8'hA3, 32'h33333333, k);
    wait_idle(800);
    chk("three_count", log_b.size(), n0 + 14);
    chk("three_first_op", log_b[n0+1], 8'hA1);
    chk("three_second_op", log_b[n0+8], 8'hA2);
    chk("three_back_to_back", log_e[n0+7] - log_e[n0+6], BP);
    chk("three_drop", drop_count, 1);
    n0 = log_b.size();
    rise_cmd(8'hB1, 32'h01010101, k);
    rise_cmd(8'hB2, 32'h02020202, n1);
    while (edges < k + 7 * BP - 1) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.opcode = 8'hB3;
    bus.command = 32'h03030303;
    @(negedge clk) bus.cmd_valid = 1'b0;
    wait_idle(1200);
    chk("refill_count", log_b.size(), n0 + 21);
    chk("refill_op1", log_b[n0+1], 8'hB1);
    chk("refill_op2", log_b[n0+8], 8'hB2);
    chk("refill_op3", log_b[n0+15], 8'hB3);
    chk("refill_drop", drop_count, 1);
    rise_cmd(8'hC0, 32'h0, k);
    rise_cmd(8'hC1, 32'h1, k);
    for (int i = 0; i < 300; i++) rise_cmd(8'($urandom), $urandom, k);
    chk("sat_drop", drop_count, 255);
    wait_idle(1500);
    chk("sat_drop_after", drop_count, 255);
    n0 = log_b.size();
    rise_cmd(8'hD7, 32'hDEADBEEF, k);
    for (int i = 0; i < 400 && log_b.size() < n0 + 4; i++) begin
      @(negedge clk);
      #1;
    end
    chk("reached_byte3", log_b.size(), n0 + 4);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_trans_en", bus.trans_en, 0);
    chk("async_data_out", bus.data_out, 0);
    chk("async_busy", busy, 0);
    chk("async_drop", drop_count, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    n1 = log_b.size();
    repeat (300) @(negedge clk);
    chk("no_strobe_after_reset", log_b.size(), n1);
    rise_cmd(8'hE1, 32'h89ABCDEF, k);
    wait_idle(400);
    chk("post_reset_count", log_b.size(), n1 + 7);
    chk("post_reset_checksum", log_b[n1+6], pkt_byte(8'hE1, 32'h89ABCDEF, 6));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bus.cmd_valid = ~bus.cmd_valid;
      bus.opcode = 8'($urandom);
      bus.command = $urandom;
    end
    @(negedge clk) bus.cmd_valid = 1'b0;
    wait_idle(1500);
    chk("all_expected_sent", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
